// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand/opcode decode into a 2-entry skid buffer.
// Define ALU_ISSUE_CNT_EN to enable the issued-operation counter on count_o.
module alu_issue_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  aluop_i,
  input  logic [5:0]  funct_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] src1_o,
  output logic [31:0] src2_o,
  output logic [3:0]  ctrl_o,
  output logic        illegal_o,
  output logic [15:0] count_o
);

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ctrl;
    logic        ill;
  } op_t;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]  state, state_nxt;
  op_t         head, tail, dec;
  logic [31:0] sext, zext;
  logic        push, pop;
  logic        head_ld, head_shift, tail_ld;

  assign sext = {{16{imm_i[15]}}, imm_i};
  assign zext = {16'h0000, imm_i};

  always_comb begin
    dec.src1 = rs_data_i;
    dec.src2 = rt_data_i;
    dec.ctrl = 4'd15;
    dec.ill  = 1'b1;
    unique case (aluop_i)
      3'd0: begin
        dec.ill = 1'b0;
        unique case (funct_i)
          6'h24: dec.ctrl = 4'd0;
          6'h25: dec.ctrl = 4'd1;
          6'h21: dec.ctrl = 4'd2;
          6'h23: dec.ctrl = 4'd3;
          6'h2B: dec.ctrl = 4'd4;
          6'h02: begin
            dec.ctrl = 4'd5;
            dec.src1 = {27'd0, shamt_i};
          end
          6'h06: dec.ctrl = 4'd13;
          6'h2A: dec.ctrl = 4'd7;
          default: begin
            dec.ctrl = 4'd15;
            dec.ill  = 1'b1;
          end
        endcase
      end
      3'd1, 3'd6: begin
        dec.ctrl = 4'd2;
        dec.src2 = sext;
        dec.ill  = 1'b0;
      end
      3'd2: begin
        dec.ctrl = 4'd3;
        dec.ill  = 1'b0;
      end
      3'd3: begin
        dec.ctrl = 4'd6;
        dec.src2 = zext;
        dec.ill  = 1'b0;
      end
      3'd4: begin
        dec.ctrl = 4'd1;
        dec.src2 = zext;
        dec.ill  = 1'b0;
      end
      3'd5: begin
        dec.ctrl = 4'd4;
        dec.src2 = sext;
        dec.ill  = 1'b0;
      end
      default: ;
    endcase
  end

  assign in_ready_o  = (state != TWO);
  assign out_valid_o = (state != EMPTY);
  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  // head is the presented (older) entry; tail only fills while head stalls
  assign head_ld    = push & ((state == EMPTY) | ((state == ONE) & pop));
  assign head_shift = pop & (state == TWO);
  assign tail_ld    = push & (state == ONE) & ~pop;

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == EMPTY): if (push) state_nxt = ONE;
      (state == ONE): begin
        if (push & ~pop)      state_nxt = TWO;
        else if (pop & ~push) state_nxt = EMPTY;
      end
      (state == TWO): if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      if (head_ld)         head <= dec;
      else if (head_shift) head <= tail;
      if (tail_ld)         tail <= dec;
    end
  end

  assign src1_o    = head.src1;
  assign src2_o    = head.src2;
  assign ctrl_o    = head.ctrl;
  assign illegal_o = head.ill;

`ifdef ALU_ISSUE_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)   cnt <= '0;
    else if (pop) cnt <= cnt + 16'd1;
  end

  assign count_o = cnt;
`else
  assign count_o = '0;
`endif

endmodule
